uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive end of the 8N1 line driven by the team's byte-to-UART transmitter.
- Synchronises the serial input and finds the start-bit falling edge.
- Samples each bit at mid-period, assembles the byte LSB first, checks the stop bit, and presents the byte in a holding register with a valid/read handshake.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even integer, legal range 4..1024; transmitter bit rate must equal clk/CLKS_PER_BIT.

Ports:
clk       input   1  system clock; all logic on rising edge.
reset     input   1  asynchronous, active-high reset.
dataIn    input   1  serial line; idle high; asynchronous to clk.
dataOut   output  8  last correctly framed byte; held until next good frame.
valid     output  1  one-cycle pulse when dataOut is updated.
pending   output  1  high while an unread byte sits in dataOut.
rxRead    input   1  consumer acknowledge; clears pending.
frameErr  output  1  one-cycle pulse when the stop bit is sampled low.
overrun   output  1  sticky; set when a good frame lands while pending=1 and rxRead=0.
busy      output  1  high in START, DATA, STOP and BREAK.

Behaviour:
- Reset values (asynchronous): dataOut=0, valid=0, pending=0, frameErr=0, overrun=0.
- Reset state is BREAK, so busy=1 out of reset.
- Input path: dataIn passes through a 2-flop synchroniser (rxs). All decisions use rxs.
- Define N=CLKS_PER_BIT and H=N/2. A bit counter (0..7) and a cycle counter (0..N-1) clear on every state entry.
- Timing reference t0: the first clk edge at which the pin is sampled low. rxs goes low at t0+2.

States:
- IDLE:
  - Stay while rxs=1.
  - rxs=0 -> START.
- START:
  - Count H cycles, then sample rxs at t0+2+H.
  - Sample 1 -> false start -> IDLE. No outputs change.
  - Sample 0 -> DATA.
- DATA:
  - Sample every N cycles. Bit i is sampled at t0+2+H+(i+1)N.
  - Shift into the shift register LSB first.
  - After bit 7 -> STOP.
- STOP:
  - Sample at t0+2+H+9N.
  - Sample 1 -> good frame -> IDLE in the same cycle. IDLE is entered at mid-stop-bit, so a start bit immediately after the stop bit is caught.
  - Sample 0 -> frameErr pulses on the next cycle; shift-register contents are discarded; dataOut, valid and pending are untouched -> BREAK.
- BREAK:
  - Wait until rxs=1, then -> IDLE.
  - A held-low line (break) produces exactly one frameErr.

Good frame, at cycle t0+3+H+9N:
- dataOut loads the shift register.
- valid=1 for exactly that cycle.
- pending=1.
- Overrun set if pending was already 1 and rxRead=0 in the stop-sample cycle. The new byte still overwrites dataOut.

Handshake:
- rxRead=1 clears pending on the next edge.
- rxRead while pending=0 is ignored.
- rxRead in the same cycle as a good-frame load: pending ends 1 (new byte wins); no overrun.
- overrun clears only on reset.

Other boundary rules:
- Glitch on the line shorter than H cycles in IDLE: rejected by the START check.
- Reset asserted mid-frame: all state is cleared immediately; the receiver re-enters BREAK and will not decode until the line has been seen high. A partial frame never produces valid or frameErr.
- Counters never wrap. The cycle counter restarts at each sample point.

Test Plan:
1. N=16, reset, line idle high, then send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 clk/bit -> valid pulse at t0+155, dataOut=0xA5, pending=1, frameErr=0.
2. Back-to-back 0x00 then 0xFF, no idle gap, rxRead pulsed after each valid -> two valid pulses 160 cycles apart, dataOut 0x00 then 0xFF, overrun=0.
3. Two frames 0x12, 0x34 with no rxRead -> second valid: dataOut=0x34, pending=1, overrun=1 and stays 1 until reset.
4. Frame 0x3C with stop bit driven 0, then line held low 100 cycles, then high -> exactly one frameErr pulse, no valid, dataOut keeps its previous value; a following frame 0x5A is received correctly.
5. 5-cycle low glitch in IDLE -> no valid, no frameErr; busy returns low by t0+11.
6. Reset asserted during bit 4 of a frame, released with line high -> no valid; the next full frame 0xC3 is received correctly. Repeat with N=4 and confirm identical decoding.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line, the received-byte holding register
// and its status/handshake signals.
//   dataIn   serial line into the receiver (idle high)
//   rxRead   consumer acknowledge of the held byte
//   dataOut  last correctly framed byte
//   valid    one-cycle pulse when dataOut is updated
//   pending  an unread byte sits in dataOut
//   frameErr one-cycle pulse on a low stop bit
//   overrun  sticky: a good frame landed on an unread byte
//   busy     receiver is inside a frame or waiting out a break
// master: the receiver. slave: the line driver / byte consumer.
interface uart_rx_if;
  logic       dataIn;
  logic       rxRead;
  logic [7:0] dataOut;
  logic       valid;
  logic       pending;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  modport master (
    input  dataIn, rxRead,
    output dataOut, valid, pending, frameErr, overrun, busy
  );

  modport slave (
    output dataIn, rxRead,
    input  dataOut, valid, pending, frameErr, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// Synchronises the line, finds the start edge, samples each bit at
// mid-period (LSB first), checks the stop bit and holds the byte with a
// valid/pending/rxRead handshake.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    uart_rx_if.master (see interface header)
// CLKS_PER_BIT: clk cycles per serial bit, even, 4..1024.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rxs to go low
// S_START | counting half a bit, then confirming the start bit is low
// S_DATA  | sampling 8 data bits, one every CLKS_PER_BIT cycles
// S_STOP  | sampling the stop bit at mid-bit
// S_BREAK | after reset or a framing error; waiting for the line high
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync;
  logic             r_rxs;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data_out;
  logic             r_valid;
  logic             r_pending;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_sample;
  logic             w_shift_en;
  logic             w_good;
  logic             w_bad;

  // Synchroniser resets low so that leaving S_BREAK requires the line to
  // actually be seen high after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 1'b0;
      r_rxs  <= 1'b0;
    end else begin
      r_sync <= bus.dataIn;
      r_rxs  <= r_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_BREAK;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cyc_cnt == HALF_CNT) begin
          w_sample    = 1'b1;
          w_state_nxt = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cyc_cnt == LAST_CNT) begin
          w_sample   = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cyc_cnt == LAST_CNT) begin
          w_sample = 1'b1;
          // Going straight to IDLE at mid-stop lets a start bit that
          // immediately follows the stop bit be caught.
          if (r_rxs) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_BREAK;
    endcase
  end

  // Both counters clear on every state change; inside S_DATA the cycle
  // counter restarts at each sample point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt <= '0;
      r_bit_cnt <= 3'd0;
    end else if (w_state_nxt != r_state) begin
      r_cyc_cnt <= '0;
      r_bit_cnt <= 3'd0;
    end else if (w_sample) begin
      r_cyc_cnt <= '0;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
      r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_shift <= 8'h00;
    else if (w_shift_en) r_shift <= {r_rxs, r_shift[7:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out  <= 8'h00;
      r_valid     <= 1'b0;
      r_pending   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid     <= w_good;
      r_frame_err <= w_bad;
      if (w_good) r_data_out <= r_shift;
      // A new byte beats a simultaneous read.
      if (w_good)           r_pending <= 1'b1;
      else if (bus.rxRead)  r_pending <= 1'b0;
      if (w_good && r_pending && !bus.rxRead) r_overrun <= 1'b1;
    end
  end

  assign bus.dataOut  = r_data_out;
  assign bus.valid    = r_valid;
  assign bus.pending  = r_pending;
  assign bus.frameErr = r_frame_err;
  assign bus.overrun  = r_overrun;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into two receivers (16 and 4 clk/bit) and
// checks them against event times and bytes derived from frame start times.
module tb_uart_rx;

  typedef struct packed {
    logic       busy;
    logic       ovr;
    logic       fe;
    logic       pend;
    logic       val;
    logic [7:0] dout;
  } st_t;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic line16 = 1'b1;
  logic line4  = 1'b1;
  logic rd16   = 1'b0;
  logic rd4    = 1'b0;
  int   cyc    = 0;
  int   act    = 0;
  int   total  = 0;
  int   bad    = 0;
  st_t  s16, s4, mon, now;

  ev_t  got_v[$], exp_v[$];
  int   got_f[$], exp_f[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if u16 ();
  uart_rx_if u4 ();

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .reset(reset), .bus(u16.master));
  uart_rx #(.CLKS_PER_BIT(4))  dut4  (.clk(clk), .reset(reset), .bus(u4.master));

  assign u16.dataIn = line16;
  assign u16.rxRead = rd16;
  assign u4.dataIn  = line4;
  assign u4.rxRead  = rd4;
  assign s16 = {u16.busy, u16.overrun, u16.frameErr, u16.pending, u16.valid, u16.dataOut};
  assign s4  = {u4.busy, u4.overrun, u4.frameErr, u4.pending, u4.valid, u4.dataOut};

  function automatic st_t cur();
    return (act != 0) ? s4 : s16;
  endfunction

  // A value registered on edge k is seen at the following negedge, where cyc==k.
  always @(negedge clk) begin
    mon = cur();
    if (mon.val === 1'b1) got_v.push_back('{c: cyc, d: mon.dout});
    if (mon.fe === 1'b1)  got_f.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input logic v);
    if (act != 0) line4 = v;
    else          line16 = v;
  endtask

  task automatic set_rd(input logic v);
    if (act != 0) rd4 = v;
    else          rd16 = v;
  endtask

  task automatic idle(input int k);
    set_line(1'b1);
    repeat (k) @(negedge clk);
  endtask

  task automatic read_pulse();
    set_rd(1'b1);
    @(negedge clk);
    set_rd(1'b0);
  endtask

  function automatic int bit_len();
    return (act != 0) ? 4 : 16;
  endfunction

  // Cycle (as seen by the monitor) at which a frame starting at t0 reports:
  // stop sampled on edge t0+2+H+9N, outputs visible in cycle t0+3+H+9N.
  function automatic int report_cyc(input int t0);
    int n;
    n = bit_len();
    return (t0 + 3 + n / 2 + 9 * n) - 1;
  endfunction

  // Must be called at a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_it);
    int         n, t0;
    logic [9:0] fr;
    n  = bit_len();
    t0 = cyc + 1;
    if (expect_it) begin
      if (stop) exp_v.push_back('{c: report_cyc(t0), d: b});
      else      exp_f.push_back(report_cyc(t0));
    end
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(fr[i]);
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_nvalid"}, got_v.size(), exp_v.size());
    chk({tag, "_nferr"}, got_f.size(), exp_f.size());
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i < got_v.size()) begin
        chk({tag, "_vcyc"}, got_v[i].c, exp_v[i].c);
        chk({tag, "_vdata"}, got_v[i].d, exp_v[i].d);
      end
    end
    for (int i = 0; i < exp_f.size(); i++) begin
      if (i < got_f.size()) chk({tag, "_fcyc"}, got_f[i], exp_f[i]);
    end
    got_v.delete();
    exp_v.delete();
    got_f.delete();
    exp_f.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    line16 = 1'b1;
    line4  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic reset_mid_frame(input logic [7:0] part, input logic [7:0] nxt);
    int n;
    n = bit_len();
    set_line(1'b0);
    repeat (n) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_line(part[i]);
      repeat (n) @(negedge clk);
    end
    set_line(part[4]);
    repeat (n / 2) @(negedge clk);
    reset = 1'b1;
    set_line(1'b1);
    repeat (2) @(negedge clk);
    now = cur();
    chk("t6_rst_busy", now.busy, 1'b1);
    chk("t6_rst_dout", now.dout, 8'h00);
    chk("t6_rst_pend", now.pend, 1'b0);
    reset = 1'b0;
    idle(2 * n);
    send_frame(nxt, 1'b1, 1'b1);
    idle(4);
    check_events("t6");
    now = cur();
    chk("t6_dout", now.dout, nxt);
  endtask

  task automatic random_frames(input int cnt);
    logic [7:0] b;
    logic       stop;
    int         gap;
    for (int i = 0; i < cnt; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, 1'b1);
      if (!stop) gap = $urandom_range(4, 8);
      else       gap = $urandom_range(0, 5);
      idle(gap);
    end
    idle(4);
    check_events("rnd");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, te, w;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    now = cur();
    chk("rst_dout", now.dout, 8'h00);
    chk("rst_valid", now.val, 1'b0);
    chk("rst_pend", now.pend, 1'b0);
    chk("rst_ferr", now.fe, 1'b0);
    chk("rst_ovr", now.ovr, 1'b0);
    chk("rst_busy", now.busy, 1'b1);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    now = cur();
    chk("idle_busy", now.busy, 1'b0);

    // single frame
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);
    check_events("t1");
    now = cur();
    chk("t1_dout", now.dout, 8'hA5);
    chk("t1_pend", now.pend, 1'b1);
    chk("t1_ovr", now.ovr, 1'b0);
    read_pulse();
    now = cur();
    chk("t1_pend_clr", now.pend, 1'b0);

    // back-to-back with reads
    fork
      begin
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          w = 0;
          while (cur().val !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
          end
          if (cur().val === 1'b1) read_pulse();
        end
      end
    join
    idle(4);
    if (got_v.size() == 2) chk("t2_gap", got_v[1].c - got_v[0].c, 160);
    check_events("t2");
    now = cur();
    chk("t2_dout", now.dout, 8'hFF);
    chk("t2_ovr", now.ovr, 1'b0);
    chk("t2_pend", now.pend, 1'b0);

    // overrun
    send_frame(8'h12, 1'b1, 1'b1);
    idle(3);
    now = cur();
    chk("t3_ovr_first", now.ovr, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(3);
    check_events("t3");
    now = cur();
    chk("t3_dout", now.dout, 8'h34);
    chk("t3_pend", now.pend, 1'b1);
    chk("t3_ovr", now.ovr, 1'b1);
    read_pulse();

    // framing error followed by a break
    send_frame(8'h3C, 1'b0, 1'b1);
    set_line(1'b0);
    repeat (100) @(negedge clk);
    idle(20);
    check_events("t4");
    now = cur();
    chk("t4_dout_held", now.dout, 8'h34);
    chk("t4_pend", now.pend, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(4);
    check_events("t4b");
    now = cur();
    chk("t4b_dout", now.dout, 8'h5A);
    chk("t4b_pend", now.pend, 1'b1);

    // short glitch
    t0 = cyc + 1;
    set_line(1'b0);
    repeat (5) @(negedge clk);
    set_line(1'b1);
    now = cur();
    chk("t5_busy_hi", now.busy, 1'b1);
    while (cyc < t0 + 10) @(negedge clk);
    now = cur();
    chk("t5_busy_lo", now.busy, 1'b0);
    idle(30);
    check_events("t5");
    now = cur();
    chk("t3_ovr_sticky", now.ovr, 1'b1);

    do_reset();
    now = cur();
    chk("rst2_ovr", now.ovr, 1'b0);
    chk("rst2_dout", now.dout, 8'h00);

    // read in the same cycle as a new byte lands
    send_frame(8'h96, 1'b1, 1'b1);
    idle(3);
    t0 = cyc + 1;
    te = report_cyc(t0);
    fork
      send_frame(8'h69, 1'b1, 1'b1);
      begin
        while (cyc < te - 1) @(negedge clk);
        read_pulse();
      end
    join
    idle(3);
    check_events("rdsame");
    now = cur();
    chk("rdsame_pend", now.pend, 1'b1);
    chk("rdsame_ovr", now.ovr, 1'b0);
    chk("rdsame_dout", now.dout, 8'h69);

    reset_mid_frame(8'h5E, 8'hC3);
    random_frames(8);

    act = 1;
    idle(8);
    reset_mid_frame(8'h5E, 8'hC3);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);
    check_events("n4_t1");
    now = cur();
    chk("n4_dout", now.dout, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b1);
    set_line(1'b0);
    repeat (40) @(negedge clk);
    idle(8);
    check_events("n4_t4");
    random_frames(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
